// File: rtl/apb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // Only slaves 1 and 2 exist on the bus; 0 and 3 are rejected without a bus cycle.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return (sel == SEL_W'(1)) || (sel == SEL_W'(2));
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin pick: on a tie, the requester not granted last wins.
module apb_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic winner_c,
  output logic any_c
);

  // Winner index: 0 selects requester 0, 1 selects requester 1.
  always_comb begin
    any_c    = valid0 | valid1;
    winner_c = (valid0 && valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two requesters onto one APB bridge and returns completion status.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_done,
  output logic              req1_done,
  output logic              req_err,
  output logic [DATA_W-1:0] req_rdata,
  output logic              transfer_Master,
  output logic              pwrite_Master,
  output logic [SEL_W-1:0]  Psel,
  output logic [ADDR_W-1:0] write_paddr_Master,
  output logic [ADDR_W-1:0] read_paddr_Master,
  output logic [DATA_W-1:0] write_data_Master,
  input  logic              penable,
  input  logic              pready_slave,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              load_bus;
  logic              xfer_d;
  logic              done0_d, done1_d;
  logic              err_d;
  logic [DATA_W-1:0] rdata_d;
  logic              winner_c, any_c;
  apb_req_t          req0_c, req1_c, win_c;

  assign req0_c  = '{write: req0_write, sel: req0_sel, addr: req0_addr, wdata: req0_wdata};
  assign req1_c  = '{write: req1_write, sel: req1_sel, addr: req1_addr, wdata: req1_wdata};
  assign win_c   = winner_c ? req1_c : req0_c;
  assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

  apb_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .winner_c   (winner_c),
    .any_c      (any_c)
  );

  // State register.
  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, arbitration, wait counting and completion status.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    load_bus     = 1'b0;
    err_d        = req_err;
    rdata_d      = req_rdata;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          grant_d = winner_c;
          if (sel_legal(win_c.sel)) begin
            state_d  = ST_ISSUE;
            load_bus = 1'b1;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (penable && pready_slave) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = pwrite_Master ? '0 : prdata;
        end else if (penable) begin
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
    xfer_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    done0_d = (state_d == ST_DONE) && (state_q != ST_DONE) && !grant_d;
    done1_d = (state_d == ST_DONE) && (state_q != ST_DONE) &&  grant_d;
  end

  // Arbitration bookkeeping and timeout counter.
  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Registered outputs; bridge fields reload only when a legal request is granted.
  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      req0_done          <= 1'b0;
      req1_done          <= 1'b0;
      req_err            <= 1'b0;
      req_rdata          <= '0;
      transfer_Master    <= 1'b0;
      pwrite_Master      <= 1'b0;
      Psel               <= '0;
      write_paddr_Master <= '0;
      read_paddr_Master  <= '0;
      write_data_Master  <= '0;
    end else begin
      req0_done       <= done0_d;
      req1_done       <= done1_d;
      req_err         <= err_d;
      req_rdata       <= rdata_d;
      transfer_Master <= xfer_d;
      if (load_bus) begin
        pwrite_Master      <= win_c.write;
        Psel               <= win_c.sel;
        write_paddr_Master <= win_c.addr;
        read_paddr_Master  <= win_c.addr;
        write_data_Master  <= win_c.wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a transaction-level reference model.
module tb_apb_req_arbiter;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        Reset = 1'b0;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [1:0]  req0_sel = 0, req1_sel = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_done, req1_done, req_err, transfer_Master, pwrite_Master;
  logic [31:0] req_rdata, write_data_Master;
  logic [1:0]  Psel;
  logic [4:0]  write_paddr_Master, read_paddr_Master;
  logic        penable = 0, pready_slave = 0;
  logic [31:0] prdata = 0;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_sel(req0_sel),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_sel(req1_sel),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_done(req0_done), .req1_done(req1_done), .req_err(req_err), .req_rdata(req_rdata),
    .transfer_Master(transfer_Master), .pwrite_Master(pwrite_Master), .Psel(Psel),
    .write_paddr_Master(write_paddr_Master), .read_paddr_Master(read_paddr_Master),
    .write_data_Master(write_data_Master),
    .penable(penable), .pready_slave(pready_slave), .prdata(prdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bridge/slave stand-in: penable from the second transfer cycle on, pready after a programmed delay.
  int   pready_delay = 0;
  int   wcnt = 0;
  logic xfer_prev = 0;
  always @(negedge pclk) begin
    if (transfer_Master && xfer_prev) begin
      penable      = 1'b1;
      pready_slave = (wcnt >= pready_delay);
    end else begin
      penable      = 1'b0;
      pready_slave = 1'b0;
      wcnt         = 0;
    end
    xfer_prev = transfer_Master;
  end
  always @(posedge pclk) if (penable && !pready_slave) wcnt++;

  // Reference model: one transaction in flight, tracked by phase and edges since grant.
  int          phase;   // 0 free, 1 on bus, 2 completing
  int          m_age, m_waits;
  logic        m_owner, m_last;
  logic        m_xfer, m_done0, m_done1, m_err, m_pwrite;
  logic [31:0] m_rdata, m_wdata;
  logic [1:0]  m_psel;
  logic [4:0]  m_addr;

  task automatic model_finish(input logic e, input logic [31:0] r);
    phase   = 2;
    m_xfer  = 0;
    m_err   = e;
    m_rdata = r;
    if (m_owner) m_done1 = 1; else m_done0 = 1;
  endtask

  always @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      phase = 0; m_age = 0; m_waits = 0; m_owner = 0; m_last = 1;
      m_xfer = 0; m_done0 = 0; m_done1 = 0; m_err = 0; m_rdata = 0;
      m_pwrite = 0; m_psel = 0; m_addr = 0; m_wdata = 0;
    end else begin
      m_done0 = 0;
      m_done1 = 0;
      if (phase == 0) begin
        if (req0_valid || req1_valid) begin
          logic [1:0] s;
          m_owner = (req0_valid && req1_valid) ? !m_last : req1_valid;
          s = m_owner ? req1_sel : req0_sel;
          if (s == 2'd1 || s == 2'd2) begin
            phase = 1; m_age = 0; m_waits = 0; m_xfer = 1; m_psel = s;
            m_pwrite = m_owner ? req1_write : req0_write;
            m_addr   = m_owner ? req1_addr  : req0_addr;
            m_wdata  = m_owner ? req1_wdata : req0_wdata;
          end else begin
            model_finish(1'b1, 32'h0);
          end
        end
      end else if (phase == 1) begin
        m_age++;
        if (m_age >= 2 && penable) begin
          if (pready_slave) model_finish(1'b0, m_pwrite ? 32'h0 : prdata);
          else begin
            m_waits++;
            if (m_waits == TO) model_finish(1'b1, 32'h0);
          end
        end
      end else begin
        phase  = 0;
        m_last = m_owner;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge pclk) begin
    #2;
    if (cmp_en) begin
      check("done0", req0_done, m_done0);
      check("done1", req1_done, m_done1);
      check("transfer", transfer_Master, m_xfer);
      check("err", req_err, m_err);
      check("rdata", req_rdata, m_rdata);
      check("pwrite", pwrite_Master, m_pwrite);
      check("psel", Psel, m_psel);
      check("waddr", write_paddr_Master, m_addr);
      check("raddr", read_paddr_Master, m_addr);
      check("wdata", write_data_Master, m_wdata);
    end
  end

  int xfer_cnt, pen_cnt;

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic wait_done(input int r, input string name, output int cyc);
    xfer_cnt = 0;
    pen_cnt  = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (transfer_Master) xfer_cnt++;
      if (penable) pen_cnt++;
      if ((r == 0) ? req0_done : req1_done) begin
        cyc = i;
        return;
      end
    end
    cyc = -1;
    check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int order[$];
    int exp_order[4];
    int dones;
    exp_order = '{0, 1, 0, 1};

    // Reset values.
    tick(); tick();
    check("rst_transfer", transfer_Master, 0);
    check("rst_done0", req0_done, 0);
    check("rst_done1", req1_done, 0);
    check("rst_err", req_err, 0);
    check("rst_psel", Psel, 0);
    Reset = 1'b1;
    cmp_en = 1;
    tick();

    // Write to slave 1, ready on first access.
    prdata = 32'hDEADBEEF; pready_delay = 0;
    req0_write = 1; req0_sel = 2'd1; req0_addr = 5'h04; req0_wdata = 32'hA5A5A5A5; req0_valid = 1;
    wait_done(0, "wr", cyc);
    req0_valid = 0;
    check("wr_latency", 32'(cyc), 32'd3);
    check("wr_xfer_cycles", 32'(xfer_cnt), 32'd2);
    check("wr_err", req_err, 0);
    check("wr_rdata", req_rdata, 32'h0);
    check("wr_psel", Psel, 2'd1);
    check("wr_addr", write_paddr_Master, 5'h04);
    check("wr_data", write_data_Master, 32'hA5A5A5A5);
    check("wr_xfer_low", transfer_Master, 0);
    tick();
    check("wr_single_done", req0_done, 0);

    // Read from slave 2 with three wait cycles.
    prdata = 32'h12345678; pready_delay = 3;
    req1_write = 0; req1_sel = 2'd2; req1_addr = 5'h10; req1_wdata = 32'h0; req1_valid = 1;
    wait_done(1, "rd", cyc);
    req1_valid = 0;
    check("rd_latency", 32'(cyc), 32'd6);
    check("rd_rdata", req_rdata, 32'h12345678);
    check("rd_err", req_err, 0);
    check("rd_raddr", read_paddr_Master, 5'h10);
    tick();

    // Tie held for four transactions: alternating grants.
    prdata = 32'hCAFE0001; pready_delay = 0;
    req0_write = 1; req0_sel = 2'd1; req0_addr = 5'h01; req0_wdata = 32'h1111;
    req1_write = 0; req1_sel = 2'd2; req1_addr = 5'h02;
    req0_valid = 1; req1_valid = 1;
    dones = 0;
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      tick();
      if (req0_done) order.push_back(0);
      if (req1_done) order.push_back(1);
      if (req0_done || req1_done) dones++;
    end
    req0_valid = 0; req1_valid = 0;
    check("tie_count", 32'(order.size()), 32'd4);
    check("tie_pulses", 32'(dones), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    tick(); tick();

    // Timeout with the slave never ready.
    pready_delay = 255;
    req0_write = 1; req0_sel = 2'd1; req0_addr = 5'h07; req0_wdata = 32'h11; req0_valid = 1;
    wait_done(0, "to", cyc);
    req0_valid = 0;
    check("to_pen_cycles", 32'(pen_cnt), 32'd4);
    check("to_err", req_err, 1);
    check("to_rdata", req_rdata, 32'h0);
    check("to_xfer_low", transfer_Master, 0);
    tick();

    // Illegal selects 3 and 0: no bus cycle, error within two cycles.
    req0_sel = 2'd3; req0_valid = 1;
    wait_done(0, "ill3", cyc);
    req0_valid = 0;
    check("ill3_fast", 32'(cyc >= 1 && cyc <= 2), 32'd1);
    check("ill3_no_xfer", 32'(xfer_cnt), 32'd0);
    check("ill3_err", req_err, 1);
    tick();
    req1_sel = 2'd0; req1_valid = 1;
    wait_done(1, "ill0", cyc);
    req1_valid = 0;
    check("ill0_no_xfer", 32'(xfer_cnt), 32'd0);
    check("ill0_err", req_err, 1);
    check("ill0_rdata", req_rdata, 32'h0);
    tick();

    // Reset during WAIT aborts silently; a later request completes.
    pready_delay = 255;
    req1_write = 0; req1_sel = 2'd2; req1_addr = 5'h1F; req1_valid = 1;
    tick(); tick(); tick();
    check("rst_mid_in_wait", penable, 1);
    Reset = 0; req1_valid = 0;
    #1;
    check("rst_mid_xfer", transfer_Master, 0);
    check("rst_mid_err", req_err, 0);
    check("rst_mid_psel", Psel, 0);
    check("rst_mid_addr", read_paddr_Master, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_done", 32'(req0_done | req1_done), 32'd0);
    end
    Reset = 1;
    tick();
    prdata = 32'h0BADF00D; pready_delay = 1;
    req1_valid = 1;
    wait_done(1, "post_rst", cyc);
    req1_valid = 0;
    check("post_rst_rdata", req_rdata, 32'h0BADF00D);
    check("post_rst_err", req_err, 0);
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum number of ACCESS wait cycles (penable=1, pready_slave=0) before abort; legal range 1..255.
REQ-002 SHALL have ports: pclk  in  1  bus clock, all state updates on its rising edge.
REQ-003 SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports, for requester 0: req0_valid, req0_write  in  1 each; req0_sel  in  2; req0_addr  in  5; req0_wdata  in  32.
REQ-005 SHALL have the same five ports for requester 1, prefixed req1_.
REQ-006 SHALL have ports: req0_done, req1_done  out  1 each  one-cycle completion pulse to the granted requester.
REQ-007 SHALL have ports: req_err  out  1  (valid with done); req_rdata  out  32  (valid with done on reads).
REQ-008 SHALL have bridge-side outputs: transfer_Master 1; pwrite_Master 1; Psel 2; write_paddr_Master 5; read_paddr_Master 5; write_data_Master 32.
REQ-009 SHALL have bridge/bus inputs: penable 1; pready_slave 1; prdata 32.

Function
REQ-010 SHALL implement a 4-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE: when either reqN_valid=1, SHALL select a winner and latch its write, sel, addr and wdata into internal registers; next state ISSUE.
REQ-012 SHALL arbitrate round-robin: both valid -> grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-013 If the latched sel is 0 or 3, SHALL skip the bus and go directly to DONE with req_err=1 and req_rdata=0.
REQ-014 ISSUE and WAIT: SHALL drive transfer_Master=1, with pwrite_Master, Psel, write_data_Master and both address outputs driven from the latched registers (write and read address both = latched addr).
REQ-015 ISSUE: next state WAIT unconditionally.
REQ-016 WAIT: on a rising edge sampling penable=1 and pready_slave=1, SHALL capture prdata on reads (0 on writes) and go to DONE with req_err=0.
REQ-017 WAIT: SHALL count edges sampling penable=1 and pready_slave=0 using an 8-bit counter cleared on entry; when the count reaches TIMEOUT, SHALL go to DONE with req_err=1 and req_rdata=0.
REQ-018 DONE: SHALL drive transfer_Master=0 and pulse the granted reqN_done for exactly one cycle, update last_grant, then return to IDLE.
REQ-019 Outside ISSUE and WAIT, transfer_Master SHALL be 0; all other bridge outputs SHALL hold their last values.
REQ-020 Requests SHALL be non-preemptive: valid changes on either requester during ISSUE, WAIT or DONE SHALL be ignored until IDLE.
REQ-021 A requester SHALL observe its done pulse no earlier than 3 cycles after it is granted in IDLE.
REQ-022 done, err and rdata SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-023 Reset=0 SHALL immediately force: state IDLE, last_grant=1, timeout counter 0, all outputs 0.
REQ-024 Reset asserted mid-transfer SHALL abort that transfer with no done pulse; after release, the requester SHALL re-request.

Structure
REQ-025 SHALL take the FSM state encoding, the TIMEOUT default and the APB address/data widths (5, 32) from a shared package apb_pkg.
REQ-026 SHALL place the 2-way round-robin pick (inputs: two valids, last_grant; output: winner) in sub-module apb_rr_pick.

Verification
REQ-027 Write: req0 write sel=1, addr=0x04, wdata=0xA5A5A5A5; slave pready=1 at first access -> transfer_Master high 2+ cycles, bridge fields match, req0_done once, req_err=0.
REQ-028 Read: req1 read sel=2, addr=0x10; prdata=0x12345678 with pready after 3 wait cycles -> req1_done with req_rdata=0x12345678, req_err=0.
REQ-029 Tie: both valid in same cycle, repeated 4 times -> grant order 0,1,0,1; each transaction gets exactly one done.
REQ-030 Timeout: TIMEOUT=4, pready held 0 -> req0_done with req_err=1, req_rdata=0 after 4 penable-high cycles; transfer_Master drops in DONE.
REQ-031 Illegal select: req0 sel=3 -> transfer_Master never asserts; req0_done with req_err=1 within 2 cycles.
REQ-032 Reset mid-WAIT: drive Reset=0 -> outputs 0 asynchronously, no done; a new request after release completes normally.
